// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped write-back cache controller.
// Holds the request opcode, bus widths, word typedefs, FSM states and
// the stored line layout.
package cache_pkg;

    localparam int unsigned ADDR_WIDTH = 6;
    localparam int unsigned DATA_WIDTH = 8;

    typedef logic [ADDR_WIDTH-1:0] UbitAddr;
    typedef logic [DATA_WIDTH-1:0] UbitData;

    typedef enum logic [1:0] {
        Op_INVALID = 2'd0,
        Op_READ    = 2'd1,
        Op_WRITE   = 2'd2
    } Op;

    typedef enum logic [1:0] {
        S_READY     = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FILL_REQ  = 2'd2,
        S_FILL_WAIT = 2'd3
    } state_e;

    // The tag is stored together with its index bits so a victim's full
    // word address can be driven straight onto the memory bus.
    typedef struct packed {
        logic    valid;
        logic    dirty;
        UbitAddr line_addr;
        UbitData data;
    } line_t;

endpackage

// File: rtl/cache_line_array.sv
// Line storage (valid, dirty, tag, data) for the cache controller.
// Ports:
//   clk, rst            - clock, async active-low clear of every line
//   rd_idx / rd_line_c  - combinational read port
//   wr_en/wr_idx/wr_line- synchronous write port
module cache_line_array
    import cache_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    output line_t                  rd_line_c,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  line_t                  wr_line
);

    localparam int unsigned NUM_LINES = 1 << INDEX_WIDTH;

    line_t lines [NUM_LINES];

    // Storage with clear-all on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                lines[i] <= '0;
            end
        end else if (wr_en) begin
            lines[wr_idx] <= wr_line;
        end
    end

    assign rd_line_c = lines[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with one-word lines.
// Ports:
//   clk, rst                         - clock, async active-low reset
//   rx_req_op/addr/data, rx_req_rdy  - processor request (accepted when rdy)
//   rx_rsp_vld, rx_rsp_data          - one-cycle read response
//   tx_req_op/addr/data              - request to the memory stage
//   tx_rsp_vld, tx_rsp_data          - memory read response
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  Op                     rx_req_op,
    input  logic [ADDR_WIDTH-1:0] rx_req_addr,
    input  logic [DATA_WIDTH-1:0] rx_req_data,
    output logic                  rx_req_rdy,
    output logic                  rx_rsp_vld,
    output logic [DATA_WIDTH-1:0] rx_rsp_data,
    output Op                     tx_req_op,
    output logic [ADDR_WIDTH-1:0] tx_req_addr,
    output logic [DATA_WIDTH-1:0] tx_req_data,
    input  logic                  tx_rsp_vld,
    input  logic [DATA_WIDTH-1:0] tx_rsp_data
);

    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

    state_e state_q, state_d;

    // Request captured at acceptance and used for the rest of a miss.
    Op       req_op_q,   req_op_d;
    UbitAddr req_addr_q, req_addr_d;
    UbitData req_data_q, req_data_d;

    logic    rdy_d;
    logic    rsp_vld_d;
    UbitData rsp_data_d;
    Op       tx_op_d;
    UbitAddr tx_addr_d;
    UbitData tx_data_d;

    line_t rd_line_c;
    logic  wr_en_c;
    line_t wr_line_c;

    logic accept_c;
    logic hit_c;
    logic victim_dirty_c;

    cache_line_array #(
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rx_req_addr[INDEX_WIDTH-1:0]),
        .rd_line_c(rd_line_c),
        .wr_en    (wr_en_c),
        .wr_idx   (req_or_in_idx()),
        .wr_line  (wr_line_c)
    );

    // Writes in READY are write hits at the incoming index; fills use the held one.
    function automatic logic [INDEX_WIDTH-1:0] req_or_in_idx();
        return (state_q == S_READY) ? rx_req_addr[INDEX_WIDTH-1:0]
                                    : req_addr_q[INDEX_WIDTH-1:0];
    endfunction

    assign accept_c       = rx_req_rdy && (rx_req_op != Op_INVALID);
    assign hit_c          = rd_line_c.valid &&
                            (rd_line_c.line_addr[ADDR_WIDTH-1 -: TAG_WIDTH] ==
                             rx_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH]);
    assign victim_dirty_c = rd_line_c.valid && rd_line_c.dirty;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_READY: begin
                if (accept_c && !hit_c) begin
                    state_d = victim_dirty_c ? S_WRITEBACK : S_FILL_REQ;
                end
            end
            S_WRITEBACK: state_d = S_FILL_REQ;
            S_FILL_REQ:  state_d = S_FILL_WAIT;
            S_FILL_WAIT: begin
                if (tx_rsp_vld) begin
                    state_d = S_READY;
                end
            end
            default:     state_d = S_READY;
        endcase
    end

    // Output logic: next values of the registered outputs plus the array write port.
    always_comb begin
        rdy_d      = (state_d == S_READY);
        rsp_vld_d  = 1'b0;
        rsp_data_d = rx_rsp_data;
        tx_op_d    = Op_INVALID;
        tx_addr_d  = tx_req_addr;
        tx_data_d  = tx_req_data;
        req_op_d   = req_op_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        wr_en_c    = 1'b0;
        wr_line_c  = '0;

        case (state_q)
            S_READY: begin
                if (accept_c) begin
                    req_op_d   = rx_req_op;
                    req_addr_d = rx_req_addr;
                    req_data_d = rx_req_data;
                    if (hit_c) begin
                        if (rx_req_op == Op_READ) begin
                            rsp_vld_d  = 1'b1;
                            rsp_data_d = rd_line_c.data;
                        end else begin
                            wr_en_c             = 1'b1;
                            wr_line_c.valid     = 1'b1;
                            wr_line_c.dirty     = 1'b1;
                            wr_line_c.line_addr = rx_req_addr;
                            wr_line_c.data      = rx_req_data;
                        end
                    end else if (victim_dirty_c) begin
                        tx_op_d   = Op_WRITE;
                        tx_addr_d = rd_line_c.line_addr;
                        tx_data_d = rd_line_c.data;
                    end else begin
                        tx_op_d   = Op_READ;
                        tx_addr_d = rx_req_addr;
                    end
                end
            end
            S_WRITEBACK: begin
                tx_op_d   = Op_READ;
                tx_addr_d = req_addr_q;
            end
            S_FILL_REQ: begin
            end
            S_FILL_WAIT: begin
                if (tx_rsp_vld) begin
                    wr_en_c             = 1'b1;
                    wr_line_c.valid     = 1'b1;
                    wr_line_c.line_addr = req_addr_q;
                    if (req_op_q == Op_WRITE) begin
                        wr_line_c.dirty = 1'b1;
                        wr_line_c.data  = req_data_q;
                    end else begin
                        wr_line_c.dirty = 1'b0;
                        wr_line_c.data  = tx_rsp_data;
                        rsp_vld_d       = 1'b1;
                        rsp_data_d      = tx_rsp_data;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Output and request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_req_rdy  <= 1'b0;
            rx_rsp_vld  <= 1'b0;
            rx_rsp_data <= '0;
            tx_req_op   <= Op_INVALID;
            tx_req_addr <= '0;
            tx_req_data <= '0;
            req_op_q    <= Op_INVALID;
            req_addr_q  <= '0;
            req_data_q  <= '0;
        end else begin
            rx_req_rdy  <= rdy_d;
            rx_rsp_vld  <= rsp_vld_d;
            rx_rsp_data <= rsp_data_d;
            tx_req_op   <= tx_op_d;
            tx_req_addr <= tx_addr_d;
            tx_req_data <= tx_data_d;
            req_op_q    <= req_op_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: transaction-level cache/memory model
// producing per-cycle expectations, directed scenarios with literal checks,
// then randomized traffic.
module tb_cache_ctrl;
    import cache_pkg::*;

    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    Op          rx_req_op;
    logic [5:0] rx_req_addr;
    logic [7:0] rx_req_data;
    logic       rx_req_rdy;
    logic       rx_rsp_vld;
    logic [7:0] rx_rsp_data;
    Op          tx_req_op;
    logic [5:0] tx_req_addr;
    logic [7:0] tx_req_data;
    logic       tx_rsp_vld;
    logic [7:0] tx_rsp_data;

    cache_ctrl #(.INDEX_WIDTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_req_op  (rx_req_op),
        .rx_req_addr(rx_req_addr),
        .rx_req_data(rx_req_data),
        .rx_req_rdy (rx_req_rdy),
        .rx_rsp_vld (rx_rsp_vld),
        .rx_rsp_data(rx_rsp_data),
        .tx_req_op  (tx_req_op),
        .tx_req_addr(tx_req_addr),
        .tx_req_data(tx_req_data),
        .tx_rsp_vld (tx_rsp_vld),
        .tx_rsp_data(tx_rsp_data)
    );

    always #5 clk = ~clk;

    // Per-cycle expectations.
    bit         exp_rdy     [MAXC];
    bit         exp_rsp_vld [MAXC];
    logic [7:0] exp_rsp_data[MAXC];
    Op          exp_tx_op   [MAXC];
    logic [5:0] exp_tx_addr [MAXC];
    logic [7:0] exp_tx_data [MAXC];

    // Reference cache and memories.
    bit         mv[8];
    bit         mdirty[8];
    logic [2:0] mt[8];
    logic [7:0] md[8];
    logic [7:0] ref_mem[64];
    logic [7:0] phys_mem[64];

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    bit         pend = 1'b0;
    logic [5:0] pend_addr = '0;

    logic       s_rdy, s_rsp_vld;
    logic [7:0] s_rsp_data, s_tx_data;
    logic [5:0] s_tx_addr;
    Op          s_tx_op;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_exp(input int from);
        for (int i = from; i < from + 16 && i < MAXC; i++) begin
            exp_rdy[i]      = 1'b1;
            exp_rsp_vld[i]  = 1'b0;
            exp_rsp_data[i] = '0;
            exp_tx_op[i]    = Op_INVALID;
            exp_tx_addr[i]  = '0;
            exp_tx_data[i]  = '0;
        end
    endtask

    // Reference behaviour for a request accepted in cycle t.
    task automatic model_accept(input Op op, input logic [5:0] a, input logic [7:0] d, input int t);
        int         idx;
        int         k;
        logic [2:0] tag;
        logic [5:0] victim;
        idx = int'(a % 8);
        tag = 3'(a / 8);
        if (mv[idx] && mt[idx] == tag) begin
            if (op == Op_READ) begin
                exp_rsp_vld[t+1]  = 1'b1;
                exp_rsp_data[t+1] = md[idx];
            end else begin
                md[idx]     = d;
                mdirty[idx] = 1'b1;
            end
        end else begin
            k = t;
            if (mv[idx] && mdirty[idx]) begin
                victim           = 6'(int'(mt[idx]) * 8 + idx);
                exp_tx_op[t+1]   = Op_WRITE;
                exp_tx_addr[t+1] = victim;
                exp_tx_data[t+1] = md[idx];
                ref_mem[victim]  = md[idx];
                k = t + 1;
            end
            exp_tx_op[k+1]   = Op_READ;
            exp_tx_addr[k+1] = a;
            for (int j = t + 1; j <= k + 2; j++) exp_rdy[j] = 1'b0;
            mv[idx] = 1'b1;
            mt[idx] = tag;
            if (op == Op_READ) begin
                md[idx]           = ref_mem[a];
                mdirty[idx]       = 1'b0;
                exp_rsp_vld[k+3]  = 1'b1;
                exp_rsp_data[k+3] = ref_mem[a];
            end else begin
                md[idx]     = d;
                mdirty[idx] = 1'b1;
            end
        end
    endtask

    // One cycle: sample and compare, act as memory, drive the next request.
    task automatic step(input Op op, input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        s_rdy      = rx_req_rdy;
        s_rsp_vld  = rx_rsp_vld;
        s_rsp_data = rx_rsp_data;
        s_tx_op    = tx_req_op;
        s_tx_addr  = tx_req_addr;
        s_tx_data  = tx_req_data;
        chk("rx_req_rdy", 32'(s_rdy), 32'(exp_rdy[cyc]));
        chk("rx_rsp_vld", 32'(s_rsp_vld), 32'(exp_rsp_vld[cyc]));
        if (exp_rsp_vld[cyc]) chk("rx_rsp_data", 32'(s_rsp_data), 32'(exp_rsp_data[cyc]));
        chk("tx_req_op", 32'(s_tx_op), 32'(exp_tx_op[cyc]));
        if (exp_tx_op[cyc] != Op_INVALID) chk("tx_req_addr", 32'(s_tx_addr), 32'(exp_tx_addr[cyc]));
        if (exp_tx_op[cyc] == Op_WRITE) chk("tx_req_data", 32'(s_tx_data), 32'(exp_tx_data[cyc]));

        if (s_tx_op == Op_WRITE) phys_mem[s_tx_addr] = s_tx_data;
        if (pend) begin
            tx_rsp_vld  = 1'b1;
            tx_rsp_data = phys_mem[pend_addr];
        end else begin
            tx_rsp_vld  = ($urandom_range(3) == 0);
            tx_rsp_data = 8'($urandom);
        end
        pend      = (s_tx_op == Op_READ);
        pend_addr = s_tx_addr;

        rx_req_op   = op;
        rx_req_addr = a;
        rx_req_data = d;
        if (exp_rdy[cyc] && op != Op_INVALID) model_accept(op, a, d, cyc);
        cyc++;
    endtask

    task automatic idle();
        step(Op_INVALID, 6'h00, 8'h00);
    endtask

    // Assert reset at a falling edge for n cycles, with junk on the inputs.
    task automatic do_reset(input int n);
        int c0;
        @(negedge clk);
        c0  = cyc;
        rst = 1'b0;
        #1;
        chk("rst rx_req_rdy", 32'(rx_req_rdy), 32'd0);
        chk("rst rx_rsp_vld", 32'(rx_rsp_vld), 32'd0);
        chk("rst rx_rsp_data", 32'(rx_rsp_data), 32'd0);
        chk("rst tx_req_op", 32'(tx_req_op), 32'(Op_INVALID));
        chk("rst tx_req_addr", 32'(tx_req_addr), 32'd0);
        chk("rst tx_req_data", 32'(tx_req_data), 32'd0);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            rx_req_op   = Op_READ;
            rx_req_addr = 6'($urandom);
            rx_req_data = 8'($urandom);
            tx_rsp_vld  = 1'b1;
            tx_rsp_data = 8'($urandom);
            cyc++;
        end
        @(negedge clk);
        chk("rst tx_req_op hold", 32'(tx_req_op), 32'(Op_INVALID));
        rst         = 1'b1;
        rx_req_op   = Op_INVALID;
        tx_rsp_vld  = 1'b1;
        tx_rsp_data = 8'($urandom);
        cyc++;
        pend = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mv[i]     = 1'b0;
            mdirty[i] = 1'b0;
        end
        clear_exp(c0);
    endtask

    initial begin
        Op          rop;
        logic [5:0] ra;
        rx_req_op   = Op_INVALID;
        rx_req_addr = '0;
        rx_req_data = '0;
        tx_rsp_vld  = 1'b0;
        tx_rsp_data = '0;
        for (int i = 0; i < MAXC; i += 16) clear_exp(i);
        for (int i = 0; i < 64; i++) begin
            ref_mem[i]  = 8'($urandom);
            phys_mem[i] = ref_mem[i];
        end
        ref_mem[6'h05] = 8'h00; phys_mem[6'h05] = 8'h00;
        ref_mem[6'h0D] = 8'h3C; phys_mem[6'h0D] = 8'h3C;
        ref_mem[6'h06] = 8'h66; phys_mem[6'h06] = 8'h66;

        do_reset(2);

        // Clean read miss: READ 0x05 at T+1, data 0x00 at T+3.
        step(Op_READ, 6'h05, 8'h00);
        idle();
        chk("miss tx_op", 32'(s_tx_op), 32'(Op_READ));
        chk("miss tx_addr", 32'(s_tx_addr), 32'h05);
        chk("miss rdy low", 32'(s_rdy), 32'd0);
        idle();
        idle();
        chk("miss rsp_vld", 32'(s_rsp_vld), 32'd1);
        chk("miss rsp_data", 32'(s_rsp_data), 32'h00);

        // Write 0xAB then read back as a hit.
        step(Op_WRITE, 6'h05, 8'hAB);
        step(Op_READ, 6'h05, 8'h00);
        idle();
        chk("hit rsp_data", 32'(s_rsp_data), 32'hAB);
        chk("hit tx_op", 32'(s_tx_op), 32'(Op_INVALID));

        // Dirty miss on 0x0D with requests ignored while busy.
        step(Op_READ, 6'h0D, 8'h00);
        step(Op_WRITE, 6'h05, 8'h11);
        chk("wb tx_op", 32'(s_tx_op), 32'(Op_WRITE));
        chk("wb tx_addr", 32'(s_tx_addr), 32'h05);
        chk("wb tx_data", 32'(s_tx_data), 32'hAB);
        step(Op_WRITE, 6'h05, 8'h11);
        chk("fill tx_op", 32'(s_tx_op), 32'(Op_READ));
        chk("fill tx_addr", 32'(s_tx_addr), 32'h0D);
        step(Op_READ, 6'h06, 8'h00);
        idle();
        chk("dirty rsp_vld", 32'(s_rsp_vld), 32'd1);
        chk("dirty rsp_data", 32'(s_rsp_data), 32'h3C);

        // Bring 0x06 and 0x05 in, then back-to-back hits.
        step(Op_READ, 6'h06, 8'h00);
        idle(); idle(); idle();
        step(Op_READ, 6'h05, 8'h00);
        idle(); idle(); idle();
        step(Op_READ, 6'h05, 8'h00);
        step(Op_READ, 6'h06, 8'h00);
        chk("b2b first", 32'(s_rsp_data), 32'hAB);
        idle();
        chk("b2b second vld", 32'(s_rsp_vld), 32'd1);
        chk("b2b second", 32'(s_rsp_data), 32'h66);

        // Reset during FILL_WAIT abandons the miss.
        step(Op_READ, 6'h15, 8'h00);
        idle();
        do_reset(3);
        step(Op_READ, 6'h05, 8'h00);
        idle();
        chk("post-rst miss", 32'(s_tx_op), 32'(Op_READ));
        idle();
        idle();
        chk("post-rst rsp", 32'(s_rsp_data), 32'hAB);

        // Randomized traffic with one reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(2))
                0:       rop = Op_INVALID;
                1:       rop = Op_READ;
                default: rop = Op_WRITE;
            endcase
            ra = {1'b0, 2'($urandom), 3'($urandom)};
            step(rop, ra, 8'($urandom));
            if (n == 750) do_reset(2);
        end
        idle(); idle(); idle(); idle(); idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
